// File: rtl/rv32_fetch_pkg.sv
// Shared definitions for the RV32 fetch stage: opcodes, FSM encoding, immediate widths.
// Optional static predictor is enabled by defining RV32_BRANCH_PREDICTION_EN.
package rv32_fetch_pkg;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam int unsigned J_IMM_W = 21;
    localparam int unsigned B_IMM_W = 13;

    localparam logic [1:0] ST_FETCH    = 2'd0;
    localparam logic [1:0] ST_BUFFERED = 2'd1;
    localparam logic [1:0] ST_DISCARD  = 2'd2;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] next_pc;
        logic        pred;
    } fetch_buf_t;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/rv32_branch_predictor.sv
// Static predictor: JAL always taken, backward conditional branches taken.
// Only compiled when RV32_BRANCH_PREDICTION_EN is defined.
`ifdef RV32_BRANCH_PREDICTION_EN
module rv32_branch_predictor
    import rv32_fetch_pkg::*;
(
    input  logic [31:0] pc_in,
    input  logic [31:0] instr_in,
    output logic        taken_out,
    output logic [31:0] target_out
);

    logic [J_IMM_W-1:0] j_imm;
    logic [B_IMM_W-1:0] b_imm;

    always_comb begin
        j_imm      = {instr_in[31], instr_in[19:12], instr_in[20], instr_in[30:21], 1'b0};
        b_imm      = {instr_in[31], instr_in[7], instr_in[30:25], instr_in[11:8], 1'b0};
        taken_out  = 1'b0;
        target_out = pc_in + 32'd4;
        if (instr_in[6:0] == OPC_JAL) begin
            taken_out  = 1'b1;
            target_out = pc_in + {{(32-J_IMM_W){j_imm[J_IMM_W-1]}}, j_imm};
        end else if (instr_in[6:0] == OPC_BRANCH && instr_in[31]) begin
            taken_out  = 1'b1;
            target_out = pc_in + {{(32-B_IMM_W){b_imm[B_IMM_W-1]}}, b_imm};
        end
    end

endmodule
`endif

// File: rtl/rv32_fetch.sv
// RV32 instruction fetch stage: PC, single-outstanding bus request, one-entry buffer.
// Define RV32_BRANCH_PREDICTION_EN to enable the static branch predictor.
module rv32_fetch
    import rv32_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_in,
    input  logic        flush_in,
    input  logic        branch_mispredicted_in,
    input  logic [31:0] branch_pc_in,
    output logic        instr_read_out,
    output logic [31:0] instr_address_out,
    input  logic [31:0] instr_read_value_in,
    input  logic        instr_ready_in,
    output logic        valid_out,
    output logic        branch_predicted_taken_out,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out
);

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    fetch_buf_t  buf_q, buf_d;
    logic        valid_q, valid_d;
    logic        pred_q, pred_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic [31:0] instr_q, instr_d;

    logic        xfer;
    logic        pred_taken;
    logic [31:0] word_next_pc;

`ifdef RV32_BRANCH_PREDICTION_EN
    logic [31:0] pred_target;

    rv32_branch_predictor u_predictor (
        .pc_in      (req_pc_q),
        .instr_in   (instr_read_value_in),
        .taken_out  (pred_taken),
        .target_out (pred_target)
    );

    assign word_next_pc = align_pc(pred_taken ? pred_target : req_pc_q + 32'd4);
`else
    assign pred_taken   = 1'b0;
    assign word_next_pc = align_pc(req_pc_q + 32'd4);
`endif

    // req_pc is the address on the bus; it differs from pc only while a stale request drains.
    assign instr_read_out    = !reset && (state_q == ST_FETCH || state_q == ST_DISCARD);
    assign instr_address_out = req_pc_q;
    assign xfer              = instr_read_out && instr_ready_in;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        buf_d    = buf_q;
        valid_d  = valid_q;
        pred_d   = pred_q;
        pc_out_d = pc_out_q;
        instr_d  = instr_q;

        if (reset) begin
            state_d  = ST_FETCH;
            pc_d     = align_pc(RESET_VECTOR);
            req_pc_d = align_pc(RESET_VECTOR);
            buf_d    = '0;
            valid_d  = 1'b0;
            pred_d   = 1'b0;
            pc_out_d = '0;
            instr_d  = '0;
        end else if (branch_mispredicted_in) begin
            pc_d    = align_pc(branch_pc_in);
            buf_d   = '0;
            valid_d = 1'b0;
            if (instr_read_out && !instr_ready_in) begin
                state_d = ST_DISCARD;
            end else begin
                state_d  = ST_FETCH;
                req_pc_d = align_pc(branch_pc_in);
            end
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (xfer && stall_in) begin
                        buf_d   = '{instr: instr_read_value_in, pc: req_pc_q,
                                    next_pc: word_next_pc, pred: pred_taken};
                        state_d = ST_BUFFERED;
                    end else if (xfer) begin
                        pc_d     = word_next_pc;
                        req_pc_d = word_next_pc;
                        valid_d  = !flush_in;
                        pred_d   = !flush_in && pred_taken;
                        if (!flush_in) begin
                            pc_out_d = req_pc_q;
                            instr_d  = instr_read_value_in;
                        end
                    end else if (!stall_in) begin
                        valid_d = 1'b0;
                        if (flush_in) pred_d = 1'b0;
                    end
                end
                ST_BUFFERED: begin
                    if (!stall_in) begin
                        state_d  = ST_FETCH;
                        pc_d     = buf_q.next_pc;
                        req_pc_d = buf_q.next_pc;
                        valid_d  = !flush_in;
                        pred_d   = !flush_in && buf_q.pred;
                        if (!flush_in) begin
                            pc_out_d = buf_q.pc;
                            instr_d  = buf_q.instr;
                        end
                    end
                end
                ST_DISCARD: begin
                    if (xfer) begin
                        state_d  = ST_FETCH;
                        req_pc_d = pc_q;
                    end
                    if (!stall_in) begin
                        valid_d = 1'b0;
                        if (flush_in) pred_d = 1'b0;
                    end
                end
                default: begin
                    state_d  = ST_FETCH;
                    req_pc_d = pc_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        state_q  <= state_d;
        pc_q     <= pc_d;
        req_pc_q <= req_pc_d;
        buf_q    <= buf_d;
        valid_q  <= valid_d;
        pred_q   <= pred_d;
        pc_out_q <= pc_out_d;
        instr_q  <= instr_d;
    end

    assign valid_out                  = valid_q;
    assign branch_predicted_taken_out = pred_q;
    assign pc_out                     = pc_out_q;
    assign instr_out                  = instr_q;

endmodule
